ysyx_22041071_wb_arb: RTL and testbench
=======================================

YSYX_22041071_WB_ARB -- requirements
Module: ysyx_22041071_wb_arb

Interface
REQ-001 SHALL have parameter LU_DEPTH, default 2: long-latency result buffer depth (power of two, >=2).
REQ-002 SHALL have parameter STARVE_MAX, default 4: consecutive lost arbitrations before a forced long-unit grant.
REQ-003 SHALL have port clk  in  1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1: synchronous, active-low reset.
REQ-005 SHALL have pipe-side ports: pipe_valid in 1; pipe_ready out 1; pipe_w_en in 1; pipe_rdest in 5; pipe_data in 64; pipe_pc in 64; pipe_ins in 32.
REQ-006 SHALL have long-unit ports (mul/div result return): lu_valid in 1; lu_ready out 1; lu_rdest in 5; lu_data in 64.
REQ-007 SHALL have register-file write port outputs: rf_w_en out 1; rf_waddr out 5; rf_wdata out 64.
REQ-008 SHALL have commit outputs for difftest: commit_valid out 1; commit_pc out 64; commit_ins out 32.
REQ-009 SHALL have lu_pending out 32: bit n set while any buffered long-unit result targets xn.

Function
REQ-010 Pipe transfer occurs when pipe_valid && pipe_ready; long-unit accept occurs when lu_valid && lu_ready.
REQ-011 lu_ready = buffer not full, combinational from state only (no dependence on lu_valid).
REQ-012 An accepted long-unit result SHALL enter the buffer tail; buffer is FIFO; results with lu_rdest==0 SHALL be accepted and discarded without entering the buffer.
REQ-013 Write port SHALL be granted once per cycle: pipe wins if the pipe transfers with pipe_w_en=1 and pipe_rdest!=0; otherwise the buffer head wins if non-empty.
REQ-014 Grant SHALL appear on rf_* registered, exactly one cycle after the winning cycle; rf_w_en=0 in cycles with no grant; rf_waddr/rf_wdata hold last values when rf_w_en=0.
REQ-015 commit_valid/pc/ins SHALL register the pipe transfer one cycle later, independent of pipe_w_en or arbitration; long-unit writes never raise commit_valid.
REQ-016 FSM states: IDLE (buffer empty), PEND (non-empty, pipe priority), FORCE (one-cycle forced long-unit grant).
REQ-017 IDLE->PEND on accept; PEND->IDLE when last entry drains with no simultaneous accept; PEND->FORCE when starvation counter reaches STARVE_MAX-1 and the pipe wins again; FORCE->PEND (or IDLE if now empty) after one cycle.
REQ-018 Starvation counter increments each cycle buffer non-empty and the pipe wins; clears on any buffer grant or when empty; saturates, never wraps.
REQ-019 In FORCE: pipe_ready=0, buffer head granted; pipe_ready=1 in all other states.
REQ-020 Simultaneous accept and drain with buffer full: lu_ready is 0, so no accept; with buffer non-full, both occur and occupancy is unchanged.
REQ-021 Accept into empty buffer SHALL NOT grant in the same cycle (earliest grant is the following cycle).
REQ-022 lu_pending SHALL reflect buffer contents after the clock edge; duplicate rdests keep the bit set until the last matching entry drains.
REQ-023 WAW ordering between pipe and long unit is guaranteed upstream by the scoreboard; this block SHALL NOT reorder or drop buffered entries.

Reset
REQ-024 When reset=0 at a rising edge: FSM->IDLE, buffer empty, counter=0, rf_w_en=0, rf_waddr=0, rf_wdata=0, commit_valid=0, commit_pc=0, commit_ins=0, lu_pending=0.
REQ-025 Reset mid-operation SHALL discard all buffered results; during reset lu_ready=0 and pipe_ready=0.

Structure
REQ-026 Bus widths (ADDR 64, INS 32, DATA 64) SHALL come from the shared define include; no local width literals.
REQ-027 Buffer SHALL be a sub-module ysyx_22041071_wb_fifo (LU_DEPTH entries, {rdest,data}, full/empty, pointer wrap with extra bit).

Verification
REQ-028 Pipe write x5=0x1234 alone -> next cycle rf_w_en=1, rf_waddr=5, rf_wdata=0x1234, commit_valid=1, commit_pc matches.
REQ-029 lu result x7=0xAA while pipe idle -> lu_pending[7]=1 next cycle; rf write x7=0xAA one cycle after grant; lu_pending[7] clears.
REQ-030 Buffer holds one entry, pipe writes every cycle -> pipe wins 4 cycles, 5th cycle pipe_ready=0 and buffered entry written; counter back to 0.
REQ-031 Two lu results accepted back-to-back with pipe writing -> lu_ready=0 on 3rd; drains in FIFO order once pipe idles.
REQ-032 lu result with rdest=0 and pipe write to x0 -> no rf_w_en, commit_valid=1 for pipe.
REQ-033 Assert reset=0 with 2 buffered entries -> next cycle all outputs zero, lu_pending=0, no later writes of discarded entries.

Source files
------------

// File: rtl/ysyx_22041071_wb_arb_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22041071_wb_arb_pkg
// Shared definitions for the write-back arbiter: bus widths, the arbiter
// FSM encoding, the long-unit result entry layout, and a register one-hot
// helper used to build the pending-destination mask.
// ---------------------------------------------------------------------------
package ysyx_22041071_wb_arb_pkg;

   // Bus widths shared with the rest of the core
   localparam int ADDR_W   = 64;
   localparam int INS_W    = 32;
   localparam int DATA_W   = 64;
   localparam int REG_AW   = 5;
   localparam int NUM_REGS = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,   // buffer empty
      ST_PEND  = 2'd1,   // buffer holds results, pipe has priority
      ST_FORCE = 2'd2    // one-cycle forced grant to the buffer head
   } arb_state_t;

   typedef struct packed {
      logic [REG_AW-1:0] rdest;
      logic [DATA_W-1:0] data;
   } lu_entry_t;

   function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] r);
      return NUM_REGS'(1) << r;
   endfunction

endpackage

// File: rtl/ysyx_22041071_wb_fifo.sv
// ---------------------------------------------------------------------------
// ysyx_22041071_wb_fifo
// FIFO of long-unit results waiting for the register-file write port.
// Pointers carry one extra wrap bit so full/empty are told apart without a
// separate counter.  Storage is a small register array so that every slot
// can be inspected each cycle to build the pending-destination mask.
//
// Ports:
//   clk, reset    clock, synchronous active-low reset (clears pointers)
//   push          write push_entry at the tail (ignored when full)
//   pop           drop the head entry (ignored when empty)
//   head          current head entry (combinational read)
//   full, empty   occupancy flags
//   count         number of stored entries
//   pending       bit n set while any stored entry targets xn
// ---------------------------------------------------------------------------
module ysyx_22041071_wb_fifo
   import ysyx_22041071_wb_arb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  lu_entry_t                push_entry,
   input  logic                     pop,
   output lu_entry_t                head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [NUM_REGS-1:0]      pending
);

   localparam int AW = $clog2(DEPTH);

   lu_entry_t               mem [DEPTH];
   logic [AW:0]             wr_ptr_reg;
   logic [AW:0]             rd_ptr_reg;
   logic [NUM_REGS-1:0]     slot_mask [DEPTH];

   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                  (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign count = wr_ptr_reg - rd_ptr_reg;
   assign head  = mem[rd_ptr_reg[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push && !full)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop && !empty)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end

   // Contents need no reset: a slot only counts once it lies inside the
   // live window between the pointers.
   always_ff @(posedge clk) begin
      if (push && !full)
         mem[wr_ptr_reg[AW-1:0]] <= push_entry;
   end

   // A slot is live when its distance from the head is below the occupancy.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
         logic [AW-1:0] slot_off;
         logic          slot_live;
         assign slot_off      = AW'(gi) - rd_ptr_reg[AW-1:0];
         assign slot_live     = ({1'b0, slot_off} < count);
         assign slot_mask[gi] = slot_live ? reg_onehot(mem[gi].rdest) : '0;
      end
   endgenerate

   always_comb begin
      pending = '0;
      for (int i = 0; i < DEPTH; i++)
         pending = pending | slot_mask[i];
   end

endmodule

// File: rtl/ysyx_22041071_wb_arb.sv
// ---------------------------------------------------------------------------
// ysyx_22041071_wb_arb
// Register-file write-back arbiter.  Shares one write port between the main
// pipe and results returning from the long-latency (mul/div) unit.  Long-unit
// results are queued; the pipe normally wins the port, but after
// STARVE_MAX consecutive losses by a non-empty queue the pipe is stalled for
// one cycle and the queue head is written.
//
// Ports:
//   clk, reset                    clock, synchronous active-low reset
//   pipe_valid/ready              pipe handshake
//   pipe_w_en/rdest/data/pc/ins   pipe write request and commit info
//   lu_valid/ready, lu_rdest/data long-unit result handshake
//   rf_w_en/waddr/wdata           registered register-file write port
//   commit_valid/pc/ins           registered commit report (pipe only)
//   lu_pending                    destinations of queued long-unit results
// ---------------------------------------------------------------------------
module ysyx_22041071_wb_arb
   import ysyx_22041071_wb_arb_pkg::*;
#(
   parameter int LU_DEPTH   = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                reset,
   // pipe side
   input  logic                pipe_valid,
   output logic                pipe_ready,
   input  logic                pipe_w_en,
   input  logic [REG_AW-1:0]   pipe_rdest,
   input  logic [DATA_W-1:0]   pipe_data,
   input  logic [ADDR_W-1:0]   pipe_pc,
   input  logic [INS_W-1:0]    pipe_ins,
   // long unit side
   input  logic                lu_valid,
   output logic                lu_ready,
   input  logic [REG_AW-1:0]   lu_rdest,
   input  logic [DATA_W-1:0]   lu_data,
   // register file write port
   output logic                rf_w_en,
   output logic [REG_AW-1:0]   rf_waddr,
   output logic [DATA_W-1:0]   rf_wdata,
   // commit
   output logic                commit_valid,
   output logic [ADDR_W-1:0]   commit_pc,
   output logic [INS_W-1:0]    commit_ins,
   output logic [NUM_REGS-1:0] lu_pending
);

   localparam int CNT_W = $clog2(LU_DEPTH) + 1;
   localparam int SW    = $clog2(STARVE_MAX + 1);

   arb_state_t        state_reg, state_next;
   logic [SW-1:0]     starve_reg, starve_next;

   lu_entry_t         lu_in;
   lu_entry_t         fifo_head;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;

   logic              pipe_xfer;
   logic              pipe_win;
   logic              lu_accept;
   logic              lu_push;
   logic              buf_grant;
   logic              last_entry;

   assign lu_in.rdest = lu_rdest;
   assign lu_in.data  = lu_data;

   // Ready depends only on state and reset, never on lu_valid.
   assign lu_ready   = reset && !fifo_full;
   assign pipe_xfer  = pipe_valid && pipe_ready;
   assign pipe_win   = pipe_xfer && pipe_w_en && (pipe_rdest != '0);
   assign lu_accept  = lu_valid && lu_ready;
   // x0 results are acknowledged but never queued.
   assign lu_push    = lu_accept && (lu_rdest != '0);
   // The head wins whenever the pipe does not claim the port; in FORCE the
   // pipe is stalled, so this also covers the forced grant.
   assign buf_grant  = reset && !pipe_win && !fifo_empty;
   assign last_entry = (fifo_count == CNT_W'(1));

   ysyx_22041071_wb_fifo #(
      .DEPTH (LU_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (lu_push),
      .push_entry (lu_in),
      .pop        (buf_grant),
      .head       (fifo_head),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .count      (fifo_count),
      .pending    (lu_pending)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg  <= ST_IDLE;
         starve_reg <= '0;
      end else begin
         state_reg  <= state_next;
         starve_reg <= starve_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      pipe_ready = reset;
      case (state_reg)
         ST_IDLE: begin
            if (lu_push)
               state_next = ST_PEND;
         end
         ST_PEND: begin
            if (buf_grant && last_entry && !lu_push)
               state_next = ST_IDLE;
            else if (pipe_win && (starve_reg == SW'(STARVE_MAX - 1)))
               state_next = ST_FORCE;
         end
         ST_FORCE: begin
            pipe_ready = 1'b0;
            state_next = (last_entry && !lu_push) ? ST_IDLE : ST_PEND;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Counts consecutive cycles in which a waiting result lost to the pipe.
   always_comb begin
      starve_next = starve_reg;
      if (fifo_empty || buf_grant)
         starve_next = '0;
      else if (pipe_win && (starve_reg != SW'(STARVE_MAX)))
         starve_next = starve_reg + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rf_w_en  <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else if (pipe_win) begin
         rf_w_en  <= 1'b1;
         rf_waddr <= pipe_rdest;
         rf_wdata <= pipe_data;
      end else if (buf_grant) begin
         rf_w_en  <= 1'b1;
         rf_waddr <= fifo_head.rdest;
         rf_wdata <= fifo_head.data;
      end else begin
         rf_w_en  <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         commit_valid <= 1'b0;
         commit_pc    <= '0;
         commit_ins   <= '0;
      end else begin
         commit_valid <= pipe_xfer;
         if (pipe_xfer) begin
            commit_pc  <= pipe_pc;
            commit_ins <= pipe_ins;
         end
      end
   end

endmodule

// File: tb/tb_ysyx_22041071_wb_arb.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22041071_wb_arb
// Directed scenarios followed by randomized traffic, all checked against a
// queue-based reference model of the write-back rules.
// ---------------------------------------------------------------------------
module tb_ysyx_22041071_wb_arb;

   localparam int LU_DEPTH   = 2;
   localparam int STARVE_MAX = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        pipe_valid, pipe_ready, pipe_w_en;
   logic [4:0]  pipe_rdest;
   logic [63:0] pipe_data, pipe_pc;
   logic [31:0] pipe_ins;
   logic        lu_valid, lu_ready;
   logic [4:0]  lu_rdest;
   logic [63:0] lu_data;
   logic        rf_w_en;
   logic [4:0]  rf_waddr;
   logic [63:0] rf_wdata;
   logic        commit_valid;
   logic [63:0] commit_pc;
   logic [31:0] commit_ins;
   logic [31:0] lu_pending;

   ysyx_22041071_wb_arb #(
      .LU_DEPTH   (LU_DEPTH),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .pipe_valid   (pipe_valid),
      .pipe_ready   (pipe_ready),
      .pipe_w_en    (pipe_w_en),
      .pipe_rdest   (pipe_rdest),
      .pipe_data    (pipe_data),
      .pipe_pc      (pipe_pc),
      .pipe_ins     (pipe_ins),
      .lu_valid     (lu_valid),
      .lu_ready     (lu_ready),
      .lu_rdest     (lu_rdest),
      .lu_data      (lu_data),
      .rf_w_en      (rf_w_en),
      .rf_waddr     (rf_waddr),
      .rf_wdata     (rf_wdata),
      .commit_valid (commit_valid),
      .commit_pc    (commit_pc),
      .commit_ins   (commit_ins),
      .lu_pending   (lu_pending)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [4:0]  rd;
      logic [63:0] d;
   } ent_t;

   ent_t        q[$];
   int          lost      = 0;
   bit          force_m   = 1'b0;
   logic        exp_w_en  = 1'b0;
   logic [4:0]  exp_waddr = '0;
   logic [63:0] exp_wdata = '0;
   logic        exp_cv    = 1'b0;
   logic [63:0] exp_pc    = '0;
   logic [31:0] exp_ins   = '0;

   function automatic logic [31:0] exp_pending();
      logic [31:0] m;
      m = '0;
      foreach (q[i]) m[q[i].rd] = 1'b1;
      return m;
   endfunction

   task automatic model_update();
      bit   xfer, pwin, bgrant, acc, fnext;
      int   sz;
      ent_t e;
      if (!reset) begin
         q.delete();
         lost = 0; force_m = 1'b0;
         exp_w_en = 1'b0; exp_waddr = '0; exp_wdata = '0;
         exp_cv = 1'b0; exp_pc = '0; exp_ins = '0;
      end else begin
         sz     = q.size();
         xfer   = pipe_valid && !force_m;
         pwin   = xfer && pipe_w_en && (pipe_rdest != 0);
         bgrant = !pwin && (sz > 0);
         acc    = lu_valid && (sz < LU_DEPTH);
         fnext  = (sz > 0) && pwin && (lost == STARVE_MAX - 1);
         if (pwin) begin
            exp_w_en = 1'b1; exp_waddr = pipe_rdest; exp_wdata = pipe_data;
         end else if (bgrant) begin
            e = q.pop_front();
            exp_w_en = 1'b1; exp_waddr = e.rd; exp_wdata = e.d;
         end else begin
            exp_w_en = 1'b0;
         end
         if (acc && lu_rdest != 0) begin
            e.rd = lu_rdest; e.d = lu_data;
            q.push_back(e);
         end
         if (sz == 0 || bgrant) lost = 0;
         else if (pwin && lost < STARVE_MAX) lost++;
         force_m = fnext;
         exp_cv = xfer;
         if (xfer) begin
            exp_pc = pipe_pc; exp_ins = pipe_ins;
         end
      end
   endtask

   // One clock: ready checks before the edge, model update at the edge,
   // registered outputs checked on the following falling edge.
   task automatic step();
      #1;
      check_val("pipe_ready", pipe_ready, reset && !force_m);
      check_val("lu_ready",   lu_ready,   reset && (q.size() < LU_DEPTH));
      @(posedge clk);
      model_update();
      @(negedge clk);
      cyc++;
      check_val("rf_w_en",      rf_w_en,      exp_w_en);
      check_val("rf_waddr",     rf_waddr,     exp_waddr);
      check_val("rf_wdata",     rf_wdata,     exp_wdata);
      check_val("commit_valid", commit_valid, exp_cv);
      check_val("commit_pc",    commit_pc,    exp_pc);
      check_val("commit_ins",   commit_ins,   exp_ins);
      check_val("lu_pending",   lu_pending,   exp_pending());
      $display("cyc %0d rst=%0b pv=%0b pw=%0b prd=%0d lv=%0b lrd=%0d | rf_w_en=%0b waddr=%0d wdata=%h cv=%0b pend=%h q=%0d",
               cyc, reset, pipe_valid, pipe_w_en, pipe_rdest, lu_valid, lu_rdest,
               rf_w_en, rf_waddr, rf_wdata, commit_valid, lu_pending, q.size());
   endtask

   task automatic drive(input bit rst, input bit pv, input bit pw, input logic [4:0] prd,
                        input logic [63:0] pd, input bit lv, input logic [4:0] lrd,
                        input logic [63:0] ld);
      reset      = rst;
      pipe_valid = pv;
      pipe_w_en  = pw;
      pipe_rdest = prd;
      pipe_data  = pd;
      pipe_pc    = {32'h8000_0000, 32'($urandom)};
      pipe_ins   = $urandom;
      lu_valid   = lv;
      lu_rdest   = lrd;
      lu_data    = ld;
      step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      // reset
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 1, 1, 3, 64'h77, 1, 4, 64'h88);
      // lone pipe write
      drive(1, 1, 1, 5, 64'h1234, 0, 0, 0);
      idle(1);
      // lone long-unit result
      drive(1, 0, 0, 0, 0, 1, 7, 64'hAA);
      idle(3);
      // starvation: one entry, pipe writes every cycle
      drive(1, 0, 0, 0, 0, 1, 9, 64'h99);
      for (int i = 0; i < 7; i++)
         drive(1, 1, 1, 3, {$urandom, $urandom}, 0, 0, 0);
      idle(2);
      // back-to-back results while pipe writes, third refused
      drive(1, 1, 1, 4, 64'h41, 1, 10, 64'h10);
      drive(1, 1, 1, 4, 64'h42, 1, 11, 64'h11);
      drive(1, 1, 1, 4, 64'h43, 1, 12, 64'h12);
      idle(3);
      // x0 from both sides
      drive(1, 1, 1, 0, 64'h55, 1, 0, 64'h66);
      idle(1);
      // duplicate destinations
      drive(1, 1, 1, 2, 64'h1, 1, 7, 64'h71);
      drive(1, 1, 1, 2, 64'h2, 1, 7, 64'h72);
      idle(3);
      // reset with two buffered entries
      drive(1, 1, 1, 6, 64'h61, 1, 13, 64'h13);
      drive(1, 1, 1, 6, 64'h62, 1, 14, 64'h14);
      drive(0, 1, 1, 6, 64'h63, 1, 15, 64'h15);
      idle(4);
      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         drive(($urandom_range(0, 99) != 0),
               ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 4) != 0),
               5'($urandom_range(0, 7)),
               {$urandom, $urandom},
               ($urandom_range(0, 2) == 0),
               5'($urandom_range(0, 7)),
               {$urandom, $urandom});
      end
      idle(4);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
